// File: rtl/key_sw_device_pkg.sv
// Shared constants for the KEY/SW bus responder: register map, control bit
// positions, default read value and the control word packer.
package key_sw_device_pkg;

    localparam logic [31:0] ADDR_KDATA = 32'hF0000010;
    localparam logic [31:0] ADDR_SDATA = 32'hF0000014;
    localparam logic [31:0] ADDR_KCTRL = 32'hF0000110;
    localparam logic [31:0] ADDR_SCTRL = 32'hF0000114;

    localparam int CTRL_READY_BIT = 0;
    localparam int CTRL_OVR_BIT   = 2;
    localparam int CTRL_IE_BIT    = 4;

    // Returned for any address that is not one of ours.
    localparam logic [31:0] DEFAULT_RDATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        REG_NONE  = 3'd0,
        REG_KDATA = 3'd1,
        REG_SDATA = 3'd2,
        REG_KCTRL = 3'd3,
        REG_SCTRL = 3'd4
    } reg_sel_e;

    // Pack the three status/control bits into the bus-visible control word.
    function automatic logic [31:0] ctrl_word(input logic ie, input logic ovr, input logic rdy);
        logic [31:0] w;
        w                 = 32'h0000_0000;
        w[CTRL_IE_BIT]    = ie;
        w[CTRL_OVR_BIT]   = ovr;
        w[CTRL_READY_BIT] = rdy;
        return w;
    endfunction

endpackage

// File: rtl/key_sw_device_debounce_sync.sv
// Two-flop synchroniser followed by a candidate/counter debouncer. A new
// value is accepted only after it has been stable for DEBOUNCE_CYCLES
// cycles; acceptance raises event_pulse for exactly one cycle.
module debounce_sync
    import key_sw_device_pkg::*;
#(
    parameter int W               = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNTBITS         = 17
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] accepted,
    output logic         event_pulse
);

    localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNTBITS-1:0] CNT_ONE  = CNTBITS'(1);

    logic [W-1:0]       sync1_r;
    logic [W-1:0]       sync2_r;
    logic [W-1:0]       cand_r;
    logic [W-1:0]       acc_r;
    logic [CNTBITS-1:0] cnt_r;
    logic               evt_r;

    // Synchronise, track the candidate value and accept it once stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
            cand_r  <= '0;
            acc_r   <= '0;
            cnt_r   <= '0;
            evt_r   <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            if (sync2_r != cand_r) begin
                // Any change restarts the stability window.
                cand_r <= sync2_r;
                cnt_r  <= '0;
                evt_r  <= 1'b0;
            end else begin
                if (cnt_r != CNT_LAST) begin
                    cnt_r <= cnt_r + CNT_ONE;
                end else begin
                    cnt_r <= cnt_r;
                end
                if ((cnt_r == CNT_LAST) && (cand_r != acc_r)) begin
                    acc_r <= cand_r;
                    evt_r <= 1'b1;
                end else begin
                    evt_r <= 1'b0;
                end
            end
        end
    end

    assign accepted    = acc_r;
    assign event_pulse = evt_r;

endmodule

// File: rtl/key_sw_device.sv
// Memory-mapped KEY/SW responder: debounced data registers, per-group
// Ready/Overrun/IE status, bus decode and a registered level interrupt.
module key_sw_device
    import key_sw_device_pkg::*;
#(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDRKDATA       = ADDR_KDATA,
    parameter logic [DBITS-1:0] ADDRSDATA       = ADDR_SDATA,
    parameter logic [DBITS-1:0] ADDRKCTRL       = ADDR_KCTRL,
    parameter logic [DBITS-1:0] ADDRSCTRL       = ADDR_SCTRL,
    parameter int               DEBOUNCE_CYCLES = 100000,
    parameter int               CNTBITS         = 17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wrdata,
    input  logic             we,
    input  logic             re,
    output logic [DBITS-1:0] rddata,
    output logic             sel,
    output logic             irq
);

    logic [3:0] k_acc_s;
    logic       k_evt_s;
    logic [9:0] s_acc_s;
    logic       s_evt_s;
    reg_sel_e   reg_sel_s;
    logic [DBITS-1:0] rddata_s;
    logic       rd_s;
    logic       k_data_rd_s, s_data_rd_s, k_ctrl_wr_s, s_ctrl_wr_s;
    logic       k_ready_r, k_ovr_r, k_ie_r;
    logic       s_ready_r, s_ovr_r, s_ie_r;
    logic       irq_r;
    logic       unused_wrdata_s;

    // Keys are active-low on the board; the register reports pressed as 1.
    debounce_sync #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNTBITS(CNTBITS)) u_key_db (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (~KEY),
        .accepted    (k_acc_s),
        .event_pulse (k_evt_s)
    );

    debounce_sync #(.W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNTBITS(CNTBITS)) u_sw_db (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (SW),
        .accepted    (s_acc_s),
        .event_pulse (s_evt_s)
    );

    // Address decode to one of the four registers.
    always_comb begin
        reg_sel_s = REG_NONE;
        if (addr == ADDRKDATA) begin
            reg_sel_s = REG_KDATA;
        end else if (addr == ADDRSDATA) begin
            reg_sel_s = REG_SDATA;
        end else if (addr == ADDRKCTRL) begin
            reg_sel_s = REG_KCTRL;
        end else if (addr == ADDRSCTRL) begin
            reg_sel_s = REG_SCTRL;
        end else begin
            reg_sel_s = REG_NONE;
        end
    end

    // Read mux; data follows addr in the same cycle.
    always_comb begin
        rddata_s = DBITS'(DEFAULT_RDATA);
        case (reg_sel_s)
            REG_KDATA: rddata_s = DBITS'({28'h0, k_acc_s});
            REG_SDATA: rddata_s = DBITS'({22'h0, s_acc_s});
            REG_KCTRL: rddata_s = DBITS'(ctrl_word(k_ie_r, k_ovr_r, k_ready_r));
            REG_SCTRL: rddata_s = DBITS'(ctrl_word(s_ie_r, s_ovr_r, s_ready_r));
            default:   rddata_s = DBITS'(DEFAULT_RDATA);
        endcase
    end

    // A simultaneous read and write is treated as a write only.
    assign rd_s        = re & ~we;
    assign k_data_rd_s = rd_s & (reg_sel_s == REG_KDATA);
    assign s_data_rd_s = rd_s & (reg_sel_s == REG_SDATA);
    assign k_ctrl_wr_s = we & (reg_sel_s == REG_KCTRL);
    assign s_ctrl_wr_s = we & (reg_sel_s == REG_SCTRL);

    // KEY status: a new event always wins over a clearing access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_ready_r <= 1'b0;
            k_ovr_r   <= 1'b0;
            k_ie_r    <= 1'b0;
        end else begin
            if (k_evt_s) begin
                k_ready_r <= 1'b1;
            end else if (k_data_rd_s) begin
                k_ready_r <= 1'b0;
            end else begin
                k_ready_r <= k_ready_r;
            end
            // A read in the event cycle consumed the old value: no overrun.
            if (k_evt_s && k_ready_r && !k_data_rd_s) begin
                k_ovr_r <= 1'b1;
            end else if (k_ctrl_wr_s && !wrdata[CTRL_OVR_BIT]) begin
                k_ovr_r <= 1'b0;
            end else begin
                k_ovr_r <= k_ovr_r;
            end
            if (k_ctrl_wr_s) begin
                k_ie_r <= wrdata[CTRL_IE_BIT];
            end else begin
                k_ie_r <= k_ie_r;
            end
        end
    end

    // SW status: same rules as the KEY group.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_ready_r <= 1'b0;
            s_ovr_r   <= 1'b0;
            s_ie_r    <= 1'b0;
        end else begin
            if (s_evt_s) begin
                s_ready_r <= 1'b1;
            end else if (s_data_rd_s) begin
                s_ready_r <= 1'b0;
            end else begin
                s_ready_r <= s_ready_r;
            end
            if (s_evt_s && s_ready_r && !s_data_rd_s) begin
                s_ovr_r <= 1'b1;
            end else if (s_ctrl_wr_s && !wrdata[CTRL_OVR_BIT]) begin
                s_ovr_r <= 1'b0;
            end else begin
                s_ovr_r <= s_ovr_r;
            end
            if (s_ctrl_wr_s) begin
                s_ie_r <= wrdata[CTRL_IE_BIT];
            end else begin
                s_ie_r <= s_ie_r;
            end
        end
    end

    // Level interrupt, registered so it trails the status bits by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= (k_ie_r & k_ready_r) | (s_ie_r & s_ready_r);
        end
    end

    // Only the IE and Overrun bits of a control write carry meaning.
    assign unused_wrdata_s = ^{wrdata[DBITS-1:5], wrdata[3], wrdata[1:0]};

    assign rddata = rddata_s;
    assign sel    = (reg_sel_s != REG_NONE);
    assign irq    = irq_r;

endmodule

// File: tb/tb_key_sw_device.sv
// Directed bench for key_sw_device with a short debounce window.
module tb_key_sw_device;
    import key_sw_device_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic        we;
    logic        re;
    logic [31:0] rddata;
    logic        sel;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_sw_device #(.DEBOUNCE_CYCLES(4), .CNTBITS(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .KEY     (KEY),
        .SW      (SW),
        .addr    (addr),
        .wrdata  (wrdata),
        .we      (we),
        .re      (re),
        .rddata  (rddata),
        .sel     (sel),
        .irq     (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        re   = 1'b0;
        we   = 1'b0;
        #1;
        chk(tag, rddata, exp);
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        re   = 1'b1;
        #1;
        chk(tag, rddata, exp);
        tick();
        re = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        wrdata = d;
        we     = 1'b1;
        tick();
        we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        reset_n = 1'b0;
        KEY = 4'hF;
        SW = 10'h000;
        addr = 32'h0;
        wrdata = 32'h0;
        we = 1'b0;
        re = 1'b0;
        #1;
        peek(ADDR_KCTRL, 32'h0, "rst_kctrl");
        peek(ADDR_SCTRL, 32'h0, "rst_sctrl");
        peek(ADDR_KDATA, 32'h0, "rst_kdata");
        chk("rst_irq", {31'h0, irq}, 32'h0);
        ticks(2);
        reset_n = 1'b1;
        ticks(2);

        // Press KEY[0]; IE is off so no interrupt.
        KEY = 4'b1110;
        ticks(10);
        peek(ADDR_KDATA, 32'h1, "key0_kdata");
        peek(ADDR_KCTRL, 32'h1, "key0_kctrl");
        chk("key0_irq", {31'h0, irq}, 32'h0);
        bus_read(ADDR_KDATA, 32'h1, "key0_read");

        // Enable KEY interrupt, then press KEY[1] only.
        bus_write(ADDR_KCTRL, 32'h10);
        peek(ADDR_KCTRL, 32'h10, "kie_kctrl");
        chk("kie_irq_idle", {31'h0, irq}, 32'h0);
        KEY = 4'b1101;
        found = 1'b0;
        addr = ADDR_KCTRL;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rddata[0] === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("key1_ready_seen", {31'h0, found}, 32'h1);
        chk("key1_irq_lag", {31'h0, irq}, 32'h0);
        tick();
        chk("key1_irq_set", {31'h0, irq}, 32'h1);
        bus_read(ADDR_KDATA, 32'h2, "key1_kdata");
        chk("key1_irq_hold", {31'h0, irq}, 32'h1);
        tick();
        chk("key1_irq_clr", {31'h0, irq}, 32'h0);
        peek(ADDR_KCTRL, 32'h10, "key1_kctrl_after");

        // Two SW changes without a read: Ready + Overrun.
        SW = 10'h005;
        ticks(10);
        peek(ADDR_SCTRL, 32'h1, "sw5_sctrl");
        SW = 10'h00A;
        ticks(10);
        peek(ADDR_SCTRL, 32'h5, "swa_sctrl_ovr");
        peek(ADDR_SDATA, 32'hA, "swa_sdata");
        bus_write(ADDR_SCTRL, 32'h0);
        peek(ADDR_SCTRL, 32'h1, "swa_ovr_clr");
        chk("swa_irq", {31'h0, irq}, 32'h0);

        // Release keys, consume, then a bounce shorter than the window.
        KEY = 4'hF;
        ticks(10);
        bus_read(ADDR_KDATA, 32'h0, "rel_kdata");
        ticks(2);
        KEY = 4'b1110;
        ticks(2);
        KEY = 4'hF;
        ticks(10);
        peek(ADDR_KDATA, 32'h0, "bounce_kdata");
        peek(ADDR_KCTRL, 32'h10, "bounce_kctrl");
        chk("bounce_irq", {31'h0, irq}, 32'h0);

        // Read KDATA continuously; the acceptance cycle coincides with a read.
        KEY = 4'b0111;
        addr = ADDR_KDATA;
        re = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rddata === 32'h8) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("race_seen", {31'h0, found}, 32'h1);
        tick();
        re = 1'b0;
        peek(ADDR_KCTRL, 32'h11, "race_kctrl");
        peek(32'hF0000020, 32'hDEADBEEF, "unmapped_rd");
        chk("unmapped_sel", {31'h0, sel}, 32'h0);
        peek(ADDR_SDATA, 32'hA, "mapped_rd");
        chk("mapped_sel", {31'h0, sel}, 32'h1);
        tick();
        chk("race_irq", {31'h0, irq}, 32'h1);

        // Reset in the middle of a SW debounce.
        SW = 10'h3FF;
        ticks(3);
        reset_n = 1'b0;
        #1;
        peek(ADDR_KCTRL, 32'h0, "mid_rst_kctrl");
        peek(ADDR_SCTRL, 32'h0, "mid_rst_sctrl");
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        peek(ADDR_SDATA, 32'h0, "mid_rst_sdata");
        ticks(2);
        reset_n = 1'b1;
        ticks(12);
        peek(ADDR_SDATA, 32'h3FF, "post_rst_sdata");
        peek(ADDR_SCTRL, 32'h1, "post_rst_sctrl");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
